// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, data width, legal
// oversampling ratios and a small voting helper.
package uart_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int PRESCALE_W = 6;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    // One-hot so each state decode is a single flop compare.
    typedef enum logic [4:0] {
        RX_IDLE   = 5'b00001,
        RX_START  = 5'b00010,
        RX_DATA   = 5'b00100,
        RX_PARITY = 5'b01000,
        RX_STOP   = 5'b10000
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side bus: serial line and frame configuration in, decoded frame
// and status pulses out.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
);
    import uart_pkg::*;

    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  Busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err, Busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err, Busy
    );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling timebase for the receiver: edge counter within a bit, data bit
// counter, end-of-bit flag and the three mid-bit sample strobes.
module uart_rx_edge_bit_counter #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic                            i_enable,
    input  logic                            i_clear,
    input  logic                            i_bit_inc,
    input  logic [uart_pkg::PRESCALE_W-1:0] i_prescale,
    output logic                            o_bit_end,
    output logic                            o_last_bit,
    output logic [2:0]                      o_sample
);
    import uart_pkg::*;

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [PRESCALE_W-1:0] w_half;

    assign w_half     = i_prescale >> 1;
    assign o_bit_end  = (r_edge_cnt == (i_prescale - PRESCALE_W'(1)));
    assign o_last_bit = (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));

    // Strobes at half-1, half and half+1 bracket the bit centre.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_strobe
            localparam int OFS = gi - 1;
            assign o_sample[gi] = (int'(r_edge_cnt) == (int'(w_half) + OFS));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_enable) begin
            if (o_bit_end) begin
                r_edge_cnt <= '0;
                if (i_bit_inc) begin
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                end
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit qualification, majority-voted LSB-first
// data capture, optional parity check and stop-bit check.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_ctrl_if.slave rx_if
);
    import uart_pkg::*;

    rx_state_e             r_state;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_frame_par_err;
    logic [2:0]            r_samples;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_busy;

    logic                  w_in_frame;
    logic                  w_bit_end;
    logic                  w_last_bit;
    logic [2:0]            w_sample;
    logic                  w_majority;
    logic                  w_expected_par;

    assign w_in_frame     = (r_state != RX_IDLE);
    assign w_majority     = majority3(r_samples[0], r_samples[1], r_samples[2]);
    assign w_expected_par = (^r_shift) ^ r_par_typ;

    // Counter is held clear in IDLE so edge_cnt is 0 in the first START cycle.
    uart_rx_edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_edge_bit_counter (
        .clk        (CLK),
        .srst       (RST),
        .i_enable   (w_in_frame),
        .i_clear    (!w_in_frame),
        .i_bit_inc  (r_state == RX_DATA),
        .i_prescale (r_prescale),
        .o_bit_end  (w_bit_end),
        .o_last_bit (w_last_bit),
        .o_sample   (w_sample)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= RX_IDLE;
            r_prescale      <= '0;
            r_par_en        <= 1'b0;
            r_par_typ       <= 1'b0;
            r_frame_par_err <= 1'b0;
            r_samples       <= '0;
            r_shift         <= '0;
            r_p_data        <= '0;
            r_data_valid    <= 1'b0;
            r_par_err       <= 1'b0;
            r_stp_err       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            for (int k = 0; k < 3; k++) begin
                if (w_sample[k]) begin
                    r_samples[k] <= rx_if.RX_IN;
                end
            end

            case (r_state)
                RX_IDLE: begin
                    if (!rx_if.RX_IN) begin
                        // Frame configuration is frozen for the whole frame.
                        r_state         <= RX_START;
                        r_prescale      <= rx_if.Prescale;
                        r_par_en        <= rx_if.PAR_EN;
                        r_par_typ       <= rx_if.PAR_TYP;
                        r_frame_par_err <= 1'b0;
                        r_busy          <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                RX_START: begin
                    if (w_bit_end) begin
                        if (w_majority) begin
                            r_state <= RX_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= RX_DATA;
                        end
                    end
                end

                RX_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= {w_majority, r_shift[DATA_WIDTH-1:1]};
                        if (w_last_bit) begin
                            r_state <= r_par_en ? RX_PARITY : RX_STOP;
                        end
                    end
                end

                RX_PARITY: begin
                    if (w_bit_end) begin
                        if (w_majority != w_expected_par) begin
                            r_par_err       <= 1'b1;
                            r_frame_par_err <= 1'b1;
                        end
                        r_state <= RX_STOP;
                    end
                end

                RX_STOP: begin
                    if (w_bit_end) begin
                        r_state <= RX_IDLE;
                        r_busy  <= 1'b0;
                        if (!w_majority) begin
                            r_stp_err <= 1'b1;
                        end else if (!r_frame_par_err) begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= RX_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.P_DATA     = r_p_data;
    assign rx_if.data_valid = r_data_valid;
    assign rx_if.par_err    = r_par_err;
    assign rx_if.stp_err    = r_stp_err;
    assign rx_if.Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a per-cycle stimulus timeline is built up
// front, a frame-level model derives the expected outputs from it.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int N = 1400;

    logic CLK = 1'b0;
    logic RST;

    uart_rx_ctrl_if rx_if ();

    uart_rx_ctrl dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (rx_if)
    );

    always #5 CLK = ~CLK;

    // stimulus timeline, one entry per cycle
    bit         line_a [N];
    bit         rst_a  [N];
    bit         pe_a   [N];
    bit         pt_a   [N];
    logic [5:0] p_a    [N];
    int         wp = 0;
    int         cur_p = 8;
    bit         cur_pe = 1'b0;
    bit         cur_pt = 1'b0;

    // expected and observed outputs per cycle
    bit         e_busy [N+2];
    bit         e_dv   [N+2];
    bit         e_pe   [N+2];
    bit         e_se   [N+2];
    logic [7:0] e_pd   [N+2];
    logic       o_busy [N+2];
    logic       o_dv   [N+2];
    logic       o_pe   [N+2];
    logic       o_se   [N+2];
    logic [7:0] o_pd   [N+2];

    int tests = 0;
    int fails = 0;
    bit built = 1'b0;
    int sA, sB, sC, sD, sE, sF, sG, sH, sI;

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    task automatic put_bits(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            line_a[wp] = b;
            rst_a[wp]  = 1'b0;
            pe_a[wp]   = cur_pe;
            pt_a[wp]   = cur_pt;
            p_a[wp]    = 6'(cur_p);
            wp++;
        end
    endtask

    task automatic put_rst(input int n);
        for (int i = 0; i < n; i++) begin
            put_bits(1'b1, 1);
            rst_a[wp-1] = 1'b1;
        end
    endtask

    // Each bit lasts p cycles, followed by one extra idle-high cycle so the
    // next frame can start in the receiver's first IDLE cycle.
    task automatic put_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                             input bit parbit, input bit stopbit, output int s);
        cur_p  = p;
        cur_pe = pe;
        cur_pt = pt;
        s = wp;
        put_bits(1'b0, p);
        for (int i = 0; i < 8; i++) put_bits(d[i], p);
        if (pe) put_bits(parbit, p);
        put_bits(stopbit, p);
        put_bits(1'b1, 1);
    endtask

    function automatic bit line_at(input int k);
        return (k < wp) ? line_a[k] : 1'b1;
    endfunction

    function automatic bit vote(input bit a, input bit b, input bit c);
        int ones;
        ones = int'(a) + int'(b) + int'(c);
        return ones >= 2;
    endfunction

    task automatic set_pd(input int from, input logic [7:0] v);
        for (int k = from; k < N + 2; k++) e_pd[k] = v;
    endtask

    // Frame-level model: walk the line, find frames, derive busy span and pulses.
    task automatic run_model();
        int t, s, p, nb, end_t, r;
        bit pe, pt, perr;
        bit m [11];
        logic [7:0] d;
        set_pd(0, 8'h00);
        t = 0;
        while (t < wp) begin
            if (rst_a[t]) begin
                set_pd(t + 1, 8'h00);
                t++;
                continue;
            end
            if (line_a[t]) begin
                t++;
                continue;
            end
            s  = t;
            p  = int'(p_a[s]);
            pe = pe_a[s];
            pt = pt_a[s];
            nb = pe ? 11 : 10;
            for (int j = 0; j < nb; j++)
                m[j] = vote(line_at(s + j*p + p/2), line_at(s + j*p + p/2 + 1), line_at(s + j*p + p/2 + 2));
            end_t = m[0] ? s + p : s + nb*p;
            r = -1;
            for (int k = s + 1; k <= end_t; k++)
                if (rst_a[k] && r < 0) r = k;
            for (int k = s + 1; k <= ((r >= 0) ? r : end_t); k++) e_busy[k] = 1'b1;
            if (r >= 0) begin
                t = r;
                continue;
            end
            if (!m[0]) begin
                for (int i = 0; i < 8; i++) d[i] = m[i+1];
                perr = pe && (m[9] != ((^d) ^ pt));
                if (perr) e_pe[s + 10*p + 1] = 1'b1;
                if (!m[nb-1]) e_se[end_t + 1] = 1'b1;
                else if (!perr) begin
                    e_dv[end_t + 1] = 1'b1;
                    set_pd(end_t + 1, d);
                end
            end
            t = end_t + 1;
        end
    endtask

    initial begin
        RST = 1'b1;
        rx_if.RX_IN    = 1'b1;
        rx_if.PAR_EN   = 1'b0;
        rx_if.PAR_TYP  = 1'b0;
        rx_if.Prescale = 6'd8;

        put_rst(3);
        put_bits(1'b1, 5);
        put_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, sA);
        put_bits(1'b1, 4);
        put_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, sB);
        // configuration moves mid-frame; the frame must keep its latched settings
        for (int k = sB + 1; k < sB + 177; k++) begin
            pe_a[k] = 1'b0;
            p_a[k]  = 6'd8;
        end
        put_bits(1'b1, 4);
        put_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, sC);
        put_bits(1'b1, 4);
        cur_p = 8; cur_pe = 1'b0; cur_pt = 1'b0;
        sD = wp;
        put_bits(1'b0, 3);
        put_bits(1'b1, 15);
        put_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, sE);
        put_bits(1'b1, 4);
        put_frame(8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, sF);
        line_a[sF + 37] = 1'b1;
        put_bits(1'b1, 4);
        put_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, sG);
        put_frame(8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, sH);
        put_bits(1'b1, 4);
        put_frame(8, 1'b0, 1'b0, 8'h56, 1'b0, 1'b1, sI);
        rst_a[sI + 30] = 1'b1;
        for (int k = sI + 31; k < wp; k++) line_a[k] = 1'b1;
        put_bits(1'b1, 6);

        run_model();
        built = 1'b1;

        // hand-computed pins on the model itself
        chk("model_dv_A", sA + 81, 32'(e_dv[sA + 81]), 32'd1);
        chk("model_pe_C", sC + 161, 32'(e_pe[sC + 161]), 32'd1);
        chk("model_se_E", sE + 321, 32'(e_se[sE + 321]), 32'd1);
        chk("model_busy_D", sD + 9, 32'(e_busy[sD + 9]), 32'd0);
        chk("model_dv_H", sG + 162, 32'(e_dv[sG + 162]), 32'd1);
    end

    // driver
    initial begin
        wait (built);
        for (int t = 0; t < wp; t++) begin
            @(negedge CLK);
            RST            = rst_a[t];
            rx_if.RX_IN    = line_a[t];
            rx_if.PAR_EN   = pe_a[t];
            rx_if.PAR_TYP  = pt_a[t];
            rx_if.Prescale = p_a[t];
        end
    end

    // compare process: outputs of cycle t are stable at the negedge inside it
    initial begin
        wait (built);
        for (int t = 0; t < wp; t++) begin
            @(negedge CLK);
            o_busy[t] = rx_if.Busy;
            o_dv[t]   = rx_if.data_valid;
            o_pe[t]   = rx_if.par_err;
            o_se[t]   = rx_if.stp_err;
            o_pd[t]   = rx_if.P_DATA;
            if (t >= 1) begin
                chk("Busy", t, 32'(o_busy[t]), 32'(e_busy[t]));
                chk("data_valid", t, 32'(o_dv[t]), 32'(e_dv[t]));
                chk("par_err", t, 32'(o_pe[t]), 32'(e_pe[t]));
                chk("stp_err", t, 32'(o_se[t]), 32'(e_se[t]));
                chk("P_DATA", t, 32'(o_pd[t]), 32'(e_pd[t]));
                if (rst_a[t-1])
                    $display("[TB] cycle %0d reset: Busy=%0d P_DATA=%02h", t, o_busy[t], o_pd[t]);
                if (e_dv[t] || e_pe[t] || e_se[t])
                    $display("[TB] cycle %0d frame: dv=%0d par_err=%0d stp_err=%0d P_DATA=%02h",
                             t, o_dv[t], o_pe[t], o_se[t], o_pd[t]);
            end
        end

        // hand-computed literal checks on the observed DUT outputs
        chk("A_busy_before", sA, 32'(o_busy[sA]), 32'd0);
        chk("A_busy_first", sA + 1, 32'(o_busy[sA + 1]), 32'd1);
        chk("A_busy_last", sA + 80, 32'(o_busy[sA + 80]), 32'd1);
        chk("A_busy_after", sA + 81, 32'(o_busy[sA + 81]), 32'd0);
        chk("A_dv_early", sA + 80, 32'(o_dv[sA + 80]), 32'd0);
        chk("A_dv", sA + 81, 32'(o_dv[sA + 81]), 32'd1);
        chk("A_data", sA + 81, 32'(o_pd[sA + 81]), 32'h0A5);
        chk("B_dv", sB + 177, 32'(o_dv[sB + 177]), 32'd1);
        chk("B_data", sB + 177, 32'(o_pd[sB + 177]), 32'h03C);
        chk("C_par_err", sC + 161, 32'(o_pe[sC + 161]), 32'd1);
        chk("C_no_dv", sC + 177, 32'(o_dv[sC + 177]), 32'd0);
        chk("C_data_held", sC + 177, 32'(o_pd[sC + 177]), 32'h03C);
        chk("D_busy_last", sD + 8, 32'(o_busy[sD + 8]), 32'd1);
        chk("D_busy_idle", sD + 9, 32'(o_busy[sD + 9]), 32'd0);
        chk("E_stp_err", sE + 321, 32'(o_se[sE + 321]), 32'd1);
        chk("E_no_dv", sE + 321, 32'(o_dv[sE + 321]), 32'd0);
        chk("F_dv", sF + 81, 32'(o_dv[sF + 81]), 32'd1);
        chk("F_data", sF + 81, 32'(o_pd[sF + 81]), 32'h000);
        chk("G_dv", sG + 81, 32'(o_dv[sG + 81]), 32'd1);
        chk("H_start", sH, 32'(sH - sG), 32'd81);
        chk("H_dv", sG + 162, 32'(o_dv[sG + 162]), 32'd1);
        chk("H_data", sG + 162, 32'(o_pd[sG + 162]), 32'h034);
        chk("I_busy_reset", sI + 31, 32'(o_busy[sI + 31]), 32'd0);
        chk("I_data_reset", sI + 31, 32'(o_pd[sI + 31]), 32'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(N * 30);
        $display("FAIL watchdog: simulation did not complete within %0d time units", N * 30);
        $fatal(1);
    end

endmodule
